// File: rtl/if_stage.sv
// rtl/if_stage.sv - Instruction fetch stage: PC register, next-PC select and IF/ID register
//
// Purpose:
//   Holds the fetch PC, selects the next PC, and captures the fetched
//   instruction into the IF/ID register. Also counts every instruction
//   that is loaded into IF/ID.
//   Next-PC priority: reset > redirect > stall > npc_sel > pc+4.
//   Optional macro IF_ADEL_EN enables fetch address-error (AdEL) detection
//   and the exccode_d port.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   stall        in   hold PC and IF/ID
//   npc_sel      in   taken jump/branch from ID
//   npc[31:0]    in   jump/branch target from ID
//   redirect     in   exception/eret redirect, overrides stall
//   redirect_pc  in   redirect target
//   imem_instr   in   instruction word at imem_addr
//   imem_addr    out  current fetch PC
//   instr_d, pc_d, pc4_d  out  IF/ID contents
//   valid_d      out  IF/ID holds a real fetched instruction
//   exccode_d    out  fetch exception code (IF_ADEL_EN only)
//   fetch_cnt    out  instructions loaded into IF/ID
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        npc_sel,
  input  logic [31:0] npc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_instr,
  output logic [31:0] imem_addr,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        valid_d,
`ifdef IF_ADEL_EN
  output logic [4:0]  exccode_d,
`endif
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] instr_q, instr_nd;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4d_q, pc4d_d;
  logic        valid_q, valid_nd;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc4;

`ifdef IF_ADEL_EN
  logic [4:0] exc_q, exc_d;
  logic       fetch_fault;

  // Misaligned or outside the instruction memory window 0x3000..0x6FFC.
  assign fetch_fault = (pc_f_q[1:0] != 2'b00) ||
                       (pc_f_q < 32'h0000_3000) ||
                       (pc_f_q > 32'h0000_6FFC);
`endif

  assign pc4 = pc_f_q + 32'd4;

  always_comb begin
    pc_f_d   = pc_f_q;
    instr_nd = instr_q;
    pcd_d    = pcd_q;
    pc4d_d   = pc4d_q;
    valid_nd = valid_q;
    cnt_d    = cnt_q;
`ifdef IF_ADEL_EN
    exc_d    = exc_q;
`endif
    if (redirect) begin
      // Redirect wins over stall and flushes IF/ID to a nop bubble.
      pc_f_d   = redirect_pc;
      instr_nd = 32'd0;
      pcd_d    = 32'd0;
      pc4d_d   = 32'd0;
      valid_nd = 1'b0;
`ifdef IF_ADEL_EN
      exc_d    = 5'd0;
`endif
    end else if (!stall) begin
      // Delay slot is architectural: npc_sel only steers the PC, IF/ID loads normally.
      pc_f_d   = npc_sel ? npc : pc4;
      instr_nd = imem_instr;
      pcd_d    = pc_f_q;
      pc4d_d   = pc4;
      valid_nd = 1'b1;
      cnt_d    = cnt_q + 32'd1;
`ifdef IF_ADEL_EN
      exc_d    = 5'd0;
      if (fetch_fault) begin
        instr_nd = 32'd0;
        exc_d    = 5'd4;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q  <= RESET_PC;
      instr_q <= 32'd0;
      pcd_q   <= 32'd0;
      pc4d_q  <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
`ifdef IF_ADEL_EN
      exc_q   <= 5'd0;
`endif
    end else begin
      pc_f_q  <= pc_f_d;
      instr_q <= instr_nd;
      pcd_q   <= pcd_d;
      pc4d_q  <= pc4d_d;
      valid_q <= valid_nd;
      cnt_q   <= cnt_d;
`ifdef IF_ADEL_EN
      exc_q   <= exc_d;
`endif
    end
  end

  assign imem_addr = pc_f_q;
  assign instr_d   = instr_q;
  assign pc_d      = pcd_q;
  assign pc4_d     = pc4d_q;
  assign valid_d   = valid_q;
  assign fetch_cnt = cnt_q;
`ifdef IF_ADEL_EN
  assign exccode_d = exc_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - Directed self-checking bench for if_stage
module tb_if_stage;

  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        reset, stall, npc_sel, redirect;
  logic [31:0] npc, redirect_pc, imem_instr, imem_addr;
  logic [31:0] instr_d, pc_d, pc4_d, fetch_cnt;
  logic        valid_d;
`ifdef IF_ADEL_EN
  logic [4:0]  exccode_d;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word content is address xor a fixed pattern.
  assign imem_instr = imem_addr ^ K;

  if_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc_sel    (npc_sel),
    .npc        (npc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_instr (imem_instr),
    .imem_addr  (imem_addr),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc4_d      (pc4_d),
    .valid_d    (valid_d),
`ifdef IF_ADEL_EN
    .exccode_d  (exccode_d),
`endif
    .fetch_cnt  (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check PC, IF/ID and counter after an edge.
  task automatic expect_state(input string tag, input logic [31:0] pc, input logic [31:0] pcd,
                              input logic [31:0] ins, input logic v, input logic [31:0] cnt);
    check({tag, ".pc"},    imem_addr, pc);
    check({tag, ".pc_d"},  pc_d, pcd);
    check({tag, ".instr"}, instr_d, ins);
    check({tag, ".valid"}, {31'd0, valid_d}, {31'd0, v});
    check({tag, ".cnt"},   fetch_cnt, cnt);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; npc_sel = 1'b0; redirect = 1'b0;
    npc = 32'd0; redirect_pc = 32'd0;
    #1;
    tick(); tick();
    expect_state("rst", 32'h3000, 32'h0, 32'h0, 1'b0, 32'd0);
    check("rst.pc4_d", pc4_d, 32'h0);

    // Reset release and sequential fetch.
    reset = 1'b0;
    tick();
    expect_state("seq1", 32'h3004, 32'h3000, 32'h3000 ^ K, 1'b1, 32'd1);
    check("seq1.pc4_d", pc4_d, 32'h3004);
    tick();
    expect_state("seq2", 32'h3008, 32'h3004, 32'h3004 ^ K, 1'b1, 32'd2);
    tick();
    expect_state("seq3", 32'h300C, 32'h3008, 32'h3008 ^ K, 1'b1, 32'd3);
    tick();
    check("seq4.pc", imem_addr, 32'h3010);

    // Taken branch: delay slot at 0x3010 still loads.
    npc_sel = 1'b1; npc = 32'h3040;
    tick();
    expect_state("br", 32'h3040, 32'h3010, 32'h3010 ^ K, 1'b1, 32'd5);
    npc = 32'h3020;
    tick();
    npc_sel = 1'b0;
    check("br2.pc", imem_addr, 32'h3020);

    // Stall for 3 cycles at 0x3020.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state("stall", 32'h3020, 32'h3040, 32'h3040 ^ K, 1'b1, 32'd6);
    end
    stall = 1'b0;
    tick();
    expect_state("resume", 32'h3024, 32'h3020, 32'h3020 ^ K, 1'b1, 32'd7);

    // stall + npc_sel holds the PC until stall ends.
    stall = 1'b1; npc_sel = 1'b1; npc = 32'h3100;
    tick();
    expect_state("stbr", 32'h3024, 32'h3020, 32'h3020 ^ K, 1'b1, 32'd7);
    stall = 1'b0;
    tick();
    expect_state("stbr2", 32'h3100, 32'h3024, 32'h3024 ^ K, 1'b1, 32'd8);
    npc_sel = 1'b0;

    // Redirect overrides stall and flushes IF/ID.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h4180;
    tick();
    expect_state("redir", 32'h4180, 32'h0, 32'h0, 1'b0, 32'd8);
    check("redir.pc4_d", pc4_d, 32'h0);
    stall = 1'b0; redirect = 1'b0;
    tick();
    expect_state("redir2", 32'h4184, 32'h4180, 32'h4180 ^ K, 1'b1, 32'd9);

    // Misaligned and out-of-range fetches.
    npc_sel = 1'b1; npc = 32'h3002;
    tick();
    npc_sel = 1'b0;
    check("adel1.pc", imem_addr, 32'h3002);
`ifdef IF_ADEL_EN
    check("adel1.exc_ok", {27'd0, exccode_d}, 32'd0);
`endif
    tick();
`ifdef IF_ADEL_EN
    expect_state("adel1", 32'h3006, 32'h3002, 32'h0, 1'b1, 32'd11);
    check("adel1.exc", {27'd0, exccode_d}, 32'd4);
`else
    expect_state("adel1", 32'h3006, 32'h3002, 32'h3002 ^ K, 1'b1, 32'd11);
`endif
    npc_sel = 1'b1; npc = 32'h7000;
    tick();
    npc_sel = 1'b0;
    tick();
`ifdef IF_ADEL_EN
    expect_state("adel2", 32'h7004, 32'h7000, 32'h0, 1'b1, 32'd13);
    check("adel2.exc", {27'd0, exccode_d}, 32'd4);
`else
    expect_state("adel2", 32'h7004, 32'h7000, 32'h7000 ^ K, 1'b1, 32'd13);
`endif
    redirect = 1'b1; redirect_pc = 32'h3000;
    tick();
    redirect = 1'b0;
`ifdef IF_ADEL_EN
    check("adel.flush", {27'd0, exccode_d}, 32'd0);
`endif
    tick();
    expect_state("back", 32'h3004, 32'h3000, 32'h3000 ^ K, 1'b1, 32'd14);

    // Counter wrap.
    stall = 1'b1;
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.cnt_q;
    #1;
    check("wrap.pre", fetch_cnt, 32'hFFFF_FFFF);
    stall = 1'b0;
    tick();
    check("wrap.cnt", fetch_cnt, 32'd0);

    // pc4 wraps silently at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    check("pcwrap.pc", imem_addr, 32'h0);
    check("pcwrap.pc4_d", pc4_d, 32'h0);
    check("pcwrap.pc_d", pc_d, 32'hFFFF_FFFC);
    check("pcwrap.cnt", fetch_cnt, 32'd1);

    // Mid-operation reset overrides redirect and stall.
    reset = 1'b1; redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h5000;
    tick();
    expect_state("rst2", 32'h3000, 32'h0, 32'h0, 1'b0, 32'd0);
    redirect = 1'b0; stall = 1'b1;
    tick();
    check("rst2.stall_ignored", imem_addr, 32'h3000);
    reset = 1'b0; stall = 1'b0;
    tick();
    expect_state("rst2.rel", 32'h3004, 32'h3000, 32'h3000 ^ K, 1'b1, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
